register_file_p: RTL and testbench
==================================

REGISTER_FILE_P -- requirements
Module: register_file_p

Interface
REQ-001 Parameter DATA_W, default 16, width of every register and bus port.
REQ-002 Parameter NUM_REGS, default 6, register count (index 0..NUM_REGS-1), legal range 4..16.
REQ-003 Parameter PC_IDX, default 3, index of the program-counter register.
REQ-004 Parameter SP_IDX, default 4, index of the stack-pointer register; SHALL differ from PC_IDX.
REQ-005 Parameter SP_RESET, default all-ones of DATA_W, stack-pointer reset value.
REQ-006 Clock and reset: one clock; reset is synchronous and active-high.
REQ-007 clock_in  input  1  sole clock, all state updates on rising edge.
REQ-008 reset_in  input  1  synchronous active-high reset.
REQ-009 bus_in  input  DATA_W  data captured by loads.
REQ-010 load_en  input  NUM_REGS  one bit per register, load bus_in at the edge.
REQ-011 out_en  input  NUM_REGS  one bit per register, request to drive bus_out.
REQ-012 pc_inc  input  1  increment PC by 1.
REQ-013 sp_inc  input  1  increment SP by 1 (pop).
REQ-014 sp_dec  input  1  decrement SP by 1 (push).
REQ-015 conflict_clr  input  1  clear sticky conflict flag.
REQ-016 bus_out  output  DATA_W  selected register value.
REQ-017 bus_oe  output  1  high when any out_en bit is high; top level uses it for tristate.
REQ-018 conflict  output  1  sticky flag, multiple out_en bits seen.

Function
REQ-019 bus_out SHALL be combinational: contents of the lowest-index register with out_en set, else zero.
REQ-020 bus_oe SHALL equal OR of out_en, combinational, zero latency.
REQ-021 bus_out SHALL show pre-edge contents when the same register is loaded that cycle (no write-through).
REQ-022 Register i SHALL take bus_in at a rising edge when load_en[i]=1; otherwise it holds, except PC/SP per REQ-023..026.
REQ-023 PC: load_en[PC_IDX] wins over pc_inc; otherwise pc_inc adds 1, modulo 2^DATA_W (max value wraps to 0).
REQ-024 SP: load_en[SP_IDX] wins over sp_inc/sp_dec; sp_inc alone adds 1, sp_dec alone subtracts 1, both SHALL leave SP unchanged.
REQ-025 SP arithmetic SHALL wrap modulo 2^DATA_W in both directions (0 minus 1 gives all-ones).
REQ-026 Increments SHALL act at the same edge as loads to other registers; all updates apply in one cycle.
REQ-027 conflict SHALL set at the edge after any cycle with two or more out_en bits high and stay set until cleared.
REQ-028 conflict_clr SHALL clear conflict at the edge; simultaneous new conflict SHALL win (flag stays 1).
REQ-029 Multiple load_en bits high SHALL load every selected register with the same bus_in; no error.
REQ-030 Control bits above NUM_REGS-1 do not exist; out-of-range indices SHALL be a parameter elaboration error.

Reset
REQ-031 At a rising edge with reset_in=1, all registers SHALL go to 0 except SP, which goes to SP_RESET; conflict SHALL go to 0.
REQ-032 Reset SHALL override load, increment and clear in the same cycle; a sequence interrupted by reset SHALL not resume.
REQ-033 bus_out/bus_oe SHALL stay combinational during reset, following out_en and the current register contents.

Structure
REQ-034 Shared package cpup_reg_pkg SHALL hold default DATA_W, NUM_REGS, PC_IDX, SP_IDX, SP_RESET and named index constants for A, B, C, P, S, ST (0..5).
REQ-035 One sub-module, reg_counter_cell (load/inc/dec/hold, DATA_W parametrised), SHALL implement PC and SP; plain registers are inline.

Verification
REQ-036 Reset, then out_en=6'b010000 -> bus_out=16'hFFFF, bus_oe=1; out_en=6'b000001 -> bus_out=16'h0000.
REQ-037 bus_in=16'h1234, load_en[0]=1 and out_en[0]=1 same cycle -> bus_out=0000 that cycle, 1234 next cycle.
REQ-038 Load PC=16'hFFFF, then pc_inc for one cycle -> PC=16'h0000; pc_inc together with load 16'h0010 -> PC=16'h0010.
REQ-039 SP=16'h0000: sp_dec -> 16'hFFFF; sp_inc+sp_dec together -> unchanged; sp_dec together with load 16'h0100 -> 16'h0100.
REQ-040 A=16'h0001, B=16'h0002, out_en=6'b000011 -> bus_out=16'h0001; conflict=1 next cycle, held until conflict_clr; clear with out_en=6'b000011 still high -> conflict stays 1.
REQ-041 Reset asserted while pc_inc and load_en all high -> all registers 0, SP=SP_RESET, conflict=0 after the edge.

Source files
------------

// File: rtl/cpup_reg_pkg.sv
// Shared defaults, register index names and counter-op helpers for the CPU register file.
package cpup_reg_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 6;

  // Named register slots
  localparam int REG_A  = 0;
  localparam int REG_B  = 1;
  localparam int REG_C  = 2;
  localparam int REG_P  = 3;
  localparam int REG_S  = 4;
  localparam int REG_ST = 5;

  localparam int                    DEF_PC_IDX   = REG_P;
  localparam int                    DEF_SP_IDX   = REG_S;
  localparam logic [DEF_DATA_W-1:0] DEF_SP_RESET = '1;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_LOAD = 2'd1,
    CNT_INC  = 2'd2,
    CNT_DEC  = 2'd3
  } cnt_op_e;

  // Load beats increment.
  function automatic cnt_op_e pc_op(input logic load, input logic inc);
    if (load)     return CNT_LOAD;
    else if (inc) return CNT_INC;
    else          return CNT_HOLD;
  endfunction

  // Load beats push/pop; push and pop together cancel out.
  function automatic cnt_op_e sp_op(input logic load, input logic inc, input logic dec);
    if (load)             return CNT_LOAD;
    else if (inc && !dec) return CNT_INC;
    else if (dec && !inc) return CNT_DEC;
    else                  return CNT_HOLD;
  endfunction

endpackage

// File: rtl/reg_counter_cell.sv
// Loadable up/down counter register used for PC and SP; wraps modulo 2^DATA_W.
module reg_counter_cell
  import cpup_reg_pkg::*;
#(
  parameter int                DATA_W  = DEF_DATA_W,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  cnt_op_e           op,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else begin
      unique case (op)
        CNT_LOAD: q <= d;
        CNT_INC:  q <= q + ONE;
        CNT_DEC:  q <= q - ONE;
        default:  q <= q;
      endcase
    end
  end

endmodule

// File: rtl/register_file_p.sv
// CPU register file: plain registers plus PC/SP counters, priority bus read, sticky read-conflict flag.
module register_file_p
  import cpup_reg_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                NUM_REGS = DEF_NUM_REGS,
  parameter int                PC_IDX   = DEF_PC_IDX,
  parameter int                SP_IDX   = DEF_SP_IDX,
  parameter logic [DATA_W-1:0] SP_RESET = '1
) (
  input  logic                clock_in,
  input  logic                reset_in,
  input  logic [DATA_W-1:0]   bus_in,
  input  logic [NUM_REGS-1:0] load_en,
  input  logic [NUM_REGS-1:0] out_en,
  input  logic                pc_inc,
  input  logic                sp_inc,
  input  logic                sp_dec,
  input  logic                conflict_clr,
  output logic [DATA_W-1:0]   bus_out,
  output logic                bus_oe,
  output logic                conflict
);

  if (NUM_REGS < 4 || NUM_REGS > 16) begin : g_bad_num_regs
    $error("register_file_p: NUM_REGS must be within 4..16");
  end
  if (PC_IDX < 0 || PC_IDX >= NUM_REGS || SP_IDX < 0 || SP_IDX >= NUM_REGS) begin : g_bad_idx
    $error("register_file_p: PC_IDX/SP_IDX out of range");
  end
  if (PC_IDX == SP_IDX) begin : g_bad_alias
    $error("register_file_p: PC_IDX and SP_IDX must differ");
  end

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic                            multi_oe;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (i == PC_IDX) begin : g_pc
      reg_counter_cell #(.DATA_W(DATA_W), .RST_VAL('0)) u_pc (
        .clk (clock_in),
        .rst (reset_in),
        .op  (pc_op(load_en[i], pc_inc)),
        .d   (bus_in),
        .q   (regs[i])
      );
    end else if (i == SP_IDX) begin : g_sp
      reg_counter_cell #(.DATA_W(DATA_W), .RST_VAL(SP_RESET)) u_sp (
        .clk (clock_in),
        .rst (reset_in),
        .op  (sp_op(load_en[i], sp_inc, sp_dec)),
        .d   (bus_in),
        .q   (regs[i])
      );
    end else begin : g_plain
      always_ff @(posedge clock_in) begin
        if (reset_in)        regs[i] <= '0;
        else if (load_en[i]) regs[i] <= bus_in;
      end
    end
  end

  // Lowest index wins: scan downward so the last hit is the smallest index.
  always_comb begin
    bus_out = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (out_en[i]) bus_out = regs[i];
    end
  end

  assign bus_oe   = |out_en;
  assign multi_oe = |(out_en & (out_en - 1'b1));

  // A fresh conflict outranks a clear in the same cycle.
  always_ff @(posedge clock_in) begin
    if (reset_in)          conflict <= 1'b0;
    else if (multi_oe)     conflict <= 1'b1;
    else if (conflict_clr) conflict <= 1'b0;
  end

endmodule

// File: tb/tb_register_file_p.sv
// Directed-vector bench for register_file_p with hand-computed expectations.
module tb_register_file_p;

  logic        clock_in = 1'b0;
  logic        reset_in;
  logic [15:0] bus_in;
  logic [5:0]  load_en;
  logic [5:0]  out_en;
  logic        pc_inc, sp_inc, sp_dec, conflict_clr;
  logic [15:0] bus_out;
  logic        bus_oe;
  logic        conflict;

  int n_cmp = 0;
  int n_bad = 0;

  register_file_p dut (
    .clock_in     (clock_in),
    .reset_in     (reset_in),
    .bus_in       (bus_in),
    .load_en      (load_en),
    .out_en       (out_en),
    .pc_inc       (pc_inc),
    .sp_inc       (sp_inc),
    .sp_dec       (sp_dec),
    .conflict_clr (conflict_clr),
    .bus_out      (bus_out),
    .bus_oe       (bus_oe),
    .conflict     (conflict)
  );

  always #5 clock_in = ~clock_in;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change 1ns after the edge, checks 1ns later.
  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic idle();
    load_en = '0; out_en = '0; pc_inc = 0; sp_inc = 0; sp_dec = 0; conflict_clr = 0;
  endtask

  task automatic load(input logic [5:0] sel, input logic [15:0] val);
    idle();
    load_en = sel; bus_in = val;
    step();
    idle();
  endtask

  task automatic rd(input string tag, input int idx, input logic [15:0] exp);
    out_en = 6'(1 << idx);
    #1;
    chk(tag, bus_out, exp);
  endtask

  initial begin
    reset_in = 1; bus_in = '0; idle();
    step();
    reset_in = 0;

    // Reset state
    out_en = 6'b010000; #1;
    chk("rst_sp", bus_out, 16'hFFFF);
    chk("rst_oe", {15'd0, bus_oe}, 16'd1);
    chk("rst_conflict", {15'd0, conflict}, 16'd0);
    out_en = 6'b000001; #1;
    chk("rst_a", bus_out, 16'h0000);
    out_en = 6'b000000; #1;
    chk("idle_oe", {15'd0, bus_oe}, 16'd0);
    chk("idle_bus", bus_out, 16'h0000);

    // No write-through
    bus_in = 16'h1234; load_en = 6'b000001; out_en = 6'b000001; #1;
    chk("wt_same_cycle", bus_out, 16'h0000);
    step(); idle();
    rd("wt_next_cycle", 0, 16'h1234);

    // PC wrap and load priority
    load(6'b001000, 16'hFFFF);
    pc_inc = 1; step(); idle();
    rd("pc_wrap", 3, 16'h0000);
    pc_inc = 1; load_en = 6'b001000; bus_in = 16'h0010; step(); idle();
    rd("pc_load_wins", 3, 16'h0010);

    // SP wrap, cancel, load priority
    load(6'b010000, 16'h0000);
    sp_dec = 1; step(); idle();
    rd("sp_dec_wrap", 4, 16'hFFFF);
    sp_inc = 1; sp_dec = 1; step(); idle();
    rd("sp_inc_dec_hold", 4, 16'hFFFF);
    sp_inc = 1; step(); idle();
    rd("sp_inc_wrap", 4, 16'h0000);
    sp_dec = 1; load_en = 6'b010000; bus_in = 16'h0100; step(); idle();
    rd("sp_load_wins", 4, 16'h0100);

    // Same-edge updates across registers
    pc_inc = 1; sp_dec = 1; load_en = 6'b000010; bus_in = 16'hBEEF; step(); idle();
    rd("same_edge_pc", 3, 16'h0011);
    rd("same_edge_sp", 4, 16'h00FF);
    rd("same_edge_b", 1, 16'hBEEF);

    // Multi-load writes all selected registers
    load(6'b100100, 16'h5A5A);
    rd("multi_ld_c", 2, 16'h5A5A);
    rd("multi_ld_st", 5, 16'h5A5A);
    rd("multi_ld_a_kept", 0, 16'h1234);

    // Priority read and sticky conflict
    load(6'b000001, 16'h0001);
    load(6'b000010, 16'h0002);
    out_en = 6'b000011; #1;
    chk("prio_bus", bus_out, 16'h0001);
    chk("conflict_pre", {15'd0, conflict}, 16'd0);
    step(); idle();
    chk("conflict_set", {15'd0, conflict}, 16'd1);
    step();
    chk("conflict_held", {15'd0, conflict}, 16'd1);
    conflict_clr = 1; out_en = 6'b000011; step(); idle();
    chk("conflict_clr_lose", {15'd0, conflict}, 16'd1);
    conflict_clr = 1; step(); idle();
    chk("conflict_cleared", {15'd0, conflict}, 16'd0);

    // Reset overrides everything; read path stays live during reset
    out_en = 6'b011000; step(); idle();
    chk("conflict_reset_pre", {15'd0, conflict}, 16'd1);
    reset_in = 1; pc_inc = 1; sp_inc = 1; load_en = 6'b111111; bus_in = 16'hAAAA;
    out_en = 6'b000001; #1;
    chk("rst_comb_bus", bus_out, 16'h0001);
    chk("rst_comb_oe", {15'd0, bus_oe}, 16'd1);
    step();
    reset_in = 0; idle();
    chk("rst2_conflict", {15'd0, conflict}, 16'd0);
    for (int i = 0; i < 6; i++) begin
      rd($sformatf("rst2_r%0d", i), i, (i == 4) ? 16'hFFFF : 16'h0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
